fetch_sequencer: RTL and testbench

Front-end controller that drives the instruction cache and feeds `instr_buffer`. Holds the fetch PC and issues in-order fetch requests of up to `IB_PUSH_WIDTH` sequential instructions. Requests are issued only when the buffer has guaranteed room for every outstanding response (credit accounting). On a branch-mispredict redirect, it restarts fetch at a new PC and discards stale in-flight responses using an epoch tag.

---
 rtl/fetch_sequencer_pkg.sv | 43 ++++
 rtl/fetch_tag_fifo.sv | 61 ++++++
 rtl/fetch_sequencer.sv | 153 +++++++++++++++
 tb/tb_fetch_sequencer.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_sequencer_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fetch_sequencer_pkg : shared fetch types (packet, in-flight tag, FSM state)
// rev 1.0
// ---------------------------------------------------------------------------
`ifndef IB_PUSH_WIDTH
`define IB_PUSH_WIDTH 4
`endif
`ifndef IB_SZ
`define IB_SZ 16
`endif
`ifndef IB_IDX_BITS
`define IB_IDX_BITS 4
`endif

package fetch_sequencer_pkg;

   localparam int TAG_EPOCH_W = 8;
   localparam int TAG_COUNT_W = 8;

   typedef struct packed {
      logic        valid;
      logic [31:0] pc;
      logic [31:0] inst;
   } FETCH_PACKET;

   typedef struct packed {
      logic [TAG_EPOCH_W-1:0] epoch;
      logic [TAG_COUNT_W-1:0] count;
      logic [31:0]            addr;
   } FETCH_TAG;

   typedef enum logic [0:0] {
      FS_FETCH = 1'b0,
      FS_HALT  = 1'b1
   } fetch_state_e;

   function automatic logic [31:0] lane_pc(input logic [31:0] base, input int lane);
      return base + 32'(4 * lane);
   endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_tag_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fetch_tag_fifo : in-order tag FIFO tracking in-flight icache requests
// rev 1.0
// ---------------------------------------------------------------------------
module fetch_tag_fifo #(
   parameter int DEPTH = 2,
   parameter int WIDTH = 48
) (
   input  logic                           clock,
   input  logic                           reset,
   input  logic                           push,
   input  logic [WIDTH-1:0]               push_data,
   input  logic                           pop,
   output logic [WIDTH-1:0]               head,
   output logic                           full,
   output logic                           empty,
   output logic [$clog2(DEPTH+1)-1:0]     count
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic [CNT_W-1:0] used;
   logic             do_push;
   logic             do_pop;

   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      return (32'(p) == 32'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign full    = (32'(used) == 32'(DEPTH));
   assign empty   = (used == '0);
   assign count   = used;
   assign head    = mem[rd_ptr];
   assign do_pop  = pop && !empty;
   // a push into a full FIFO is legal only when the head leaves the same cycle
   assign do_push = push && (!full || do_pop);

   always_ff @(posedge clock) begin
      if (reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         used   <= '0;
      end else begin
         if (do_push) wr_ptr <= next_ptr(wr_ptr);
         if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
         if (do_push && !do_pop)      used <= used + CNT_W'(1);
         else if (do_pop && !do_push) used <= used - CNT_W'(1);
      end
   end

   always_ff @(posedge clock) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

endmodule
`default_nettype wire

// File: rtl/fetch_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fetch_sequencer : credit-checked icache fetch issue with epoch-tagged redirect
// rev 1.0
// ---------------------------------------------------------------------------
module fetch_sequencer
   import fetch_sequencer_pkg::*;
#(
   parameter int          PUSH_W   = `IB_PUSH_WIDTH,
   parameter int          IB_DEPTH = `IB_SZ,
   parameter int          MAX_OUT  = 2,
   parameter logic [31:0] RESET_PC = 32'h0
) (
   input  logic                            clock,
   input  logic                            reset,
   input  logic                            redirect_valid,
   input  logic [31:0]                     redirect_pc,
   input  logic                            halt,
   input  logic [`IB_IDX_BITS:0]           ib_available_slots,
   output logic                            icache_req_valid,
   output logic [31:0]                     icache_req_addr,
   output logic [$clog2(PUSH_W+1)-1:0]     icache_req_count,
   input  logic                            icache_req_ready,
   input  logic                            icache_rsp_valid,
   input  logic [PUSH_W-1:0][31:0]         icache_rsp_inst,
   output FETCH_PACKET [PUSH_W-1:0]        ib_push,
   output logic [$clog2(MAX_OUT+1)-1:0]    outstanding
);

   localparam int CNT_W   = $clog2(PUSH_W + 1);
   localparam int OUT_W   = $clog2(MAX_OUT + 1);
   localparam int EPOCH_W = $clog2(MAX_OUT) + 1;
   localparam int OFF_W   = $clog2(PUSH_W);
   localparam int RES_W   = $clog2(IB_DEPTH + PUSH_W + 1);

   fetch_state_e       state;
   fetch_state_e       state_next;
   logic [31:0]        pc;
   logic [EPOCH_W-1:0] epoch;
   logic [RES_W-1:0]   reserved;
   logic [RES_W-1:0]   reserved_next;

   logic [31:0]        pc_offset;
   logic [CNT_W-1:0]   req_count;
   logic               credit_ok;
   logic               req_valid;
   logic               handshake;
   logic               rsp_pop;
   logic               rsp_live;
   FETCH_TAG           push_tag;
   FETCH_TAG           head_tag;
   logic               fifo_full;
   logic               fifo_empty;
   logic [OUT_W-1:0]   fifo_count;

   generate
      if (OFF_W > 0) begin : g_offset
         assign pc_offset = 32'(pc[2 +: OFF_W]);
      end else begin : g_no_offset
         assign pc_offset = '0;
      end
   endgenerate

   // requests stop at the PUSH_W-word block boundary
   assign req_count = CNT_W'(32'(PUSH_W) - pc_offset);
   assign credit_ok = 32'(ib_available_slots) >= 32'(reserved) + 32'(req_count);
   assign req_valid = !reset && (state == FS_FETCH) && !redirect_valid && !fifo_full && credit_ok;
   assign handshake = req_valid && icache_req_ready;

   assign rsp_pop  = icache_rsp_valid && !fifo_empty;
   assign rsp_live = rsp_pop && !reset && !redirect_valid && (head_tag.epoch == TAG_EPOCH_W'(epoch));

   assign icache_req_valid = req_valid;
   assign icache_req_addr  = pc;
   assign icache_req_count = req_count;
   assign outstanding      = reset ? '0 : fifo_count;

   always_comb begin
      push_tag       = '0;
      push_tag.epoch = TAG_EPOCH_W'(epoch);
      push_tag.count = TAG_COUNT_W'(req_count);
      push_tag.addr  = pc;
   end

   fetch_tag_fifo #(
      .DEPTH (MAX_OUT),
      .WIDTH ($bits(FETCH_TAG))
   ) u_tag_fifo (
      .clock     (clock),
      .reset     (reset),
      .push      (handshake),
      .push_data (push_tag),
      .pop       (rsp_pop),
      .head      (head_tag),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   always_comb begin
      ib_push = '0;
      if (rsp_live) begin
         for (int i = 0; i < PUSH_W; i++) begin
            if (i < int'(head_tag.count)) begin
               ib_push[i].valid = 1'b1;
               ib_push[i].pc    = lane_pc(head_tag.addr, i);
               ib_push[i].inst  = icache_rsp_inst[i];
            end
         end
      end
   end

   always_comb begin
      reserved_next = reserved;
      if (handshake) reserved_next = reserved_next + RES_W'(req_count);
      if (rsp_live)  reserved_next = reserved_next - RES_W'(head_tag.count);
      // everything in flight belongs to the old epoch after a redirect
      if (redirect_valid) reserved_next = '0;
   end

   always_comb begin
      state_next = state;
      case (state)
         FS_FETCH: if (halt) state_next = FS_HALT;
         FS_HALT:  state_next = FS_HALT;
         default:  state_next = FS_FETCH;
      endcase
      if (redirect_valid) state_next = FS_FETCH;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state    <= FS_FETCH;
         pc       <= RESET_PC;
         epoch    <= '0;
         reserved <= '0;
      end else begin
         state    <= state_next;
         reserved <= reserved_next;
         if (redirect_valid) begin
            pc    <= redirect_pc & 32'hFFFF_FFFC;
            epoch <= epoch + EPOCH_W'(1);
         end else if (handshake) begin
            pc <= pc + (32'(req_count) << 2);
         end
      end
   end

   rsp_needs_tag: assert property (@(posedge clock) disable iff (reset)
                                   icache_rsp_valid |-> !fifo_empty);

endmodule
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_fetch_sequencer : directed stimulus with a request-queue reference model
// rev 1.0
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_fetch_sequencer;
   import fetch_sequencer_pkg::*;

   localparam int PW = 4;

   logic                    clock = 1'b0;
   logic                    reset = 1'b1;
   logic                    redirect_valid = 1'b0;
   logic [31:0]             redirect_pc = '0;
   logic                    halt = 1'b0;
   logic [`IB_IDX_BITS:0]   ib_available_slots = 16;
   logic                    icache_req_valid;
   logic [31:0]             icache_req_addr;
   logic [2:0]              icache_req_count;
   logic                    icache_req_ready = 1'b0;
   logic                    icache_rsp_valid = 1'b0;
   logic [PW-1:0][31:0]     icache_rsp_inst = '0;
   FETCH_PACKET [PW-1:0]    ib_push;
   logic [1:0]              outstanding;

   int checks = 0;
   int passed = 0;
   bit cmp_on = 1'b0;

   fetch_sequencer #(.PUSH_W(PW), .IB_DEPTH(16), .MAX_OUT(2), .RESET_PC(32'h0)) dut (
      .clock              (clock),
      .reset              (reset),
      .redirect_valid     (redirect_valid),
      .redirect_pc        (redirect_pc),
      .halt               (halt),
      .ib_available_slots (ib_available_slots),
      .icache_req_valid   (icache_req_valid),
      .icache_req_addr    (icache_req_addr),
      .icache_req_count   (icache_req_count),
      .icache_req_ready   (icache_req_ready),
      .icache_rsp_valid   (icache_rsp_valid),
      .icache_rsp_inst    (icache_rsp_inst),
      .ib_push            (ib_push),
      .outstanding        (outstanding)
   );

   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [64:0] got, input logic [64:0] exp);
      checks++;
      if (got === exp) passed++;
      else $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
   endtask

   // Reference: a queue of in-flight requests, each tagged with the redirect generation
   typedef struct {
      int          gen;
      int          count;
      logic [31:0] addr;
   } mreq_t;

   mreq_t       mq[$];
   logic [31:0] m_pc = 32'h0;
   int          m_gen = 0;
   bit          m_halted = 1'b0;

   always @(negedge clock) begin
      if (cmp_on) begin
         int                   cnt;
         int                   res;
         bit                   ev;
         bit                   pop;
         bit                   live;
         FETCH_PACKET [PW-1:0] ep;

         cnt = PW - int'(m_pc[3:2]);
         res = 0;
         foreach (mq[k]) if (mq[k].gen == m_gen) res += mq[k].count;
         ev   = !reset && !m_halted && !redirect_valid && (mq.size() < 2) &&
                (int'(ib_available_slots) - res >= cnt);
         pop  = !reset && icache_rsp_valid && (mq.size() > 0);
         live = pop && !redirect_valid && (mq[0].gen == m_gen);
         ep   = '0;
         if (live) begin
            for (int i = 0; i < mq[0].count; i++) begin
               ep[i].valid = 1'b1;
               ep[i].pc    = mq[0].addr + 32'(4 * i);
               ep[i].inst  = icache_rsp_inst[i];
            end
         end

         chk("model_req_valid", 65'(icache_req_valid), 65'(ev));
         if (ev) begin
            chk("model_req_addr", 65'(icache_req_addr), 65'(m_pc));
            chk("model_req_count", 65'(icache_req_count), 65'(cnt));
         end
         for (int i = 0; i < PW; i++)
            chk($sformatf("model_ib_push[%0d]", i), 65'(ib_push[i]), 65'(ep[i]));
         chk("model_outstanding", 65'(outstanding), reset ? 65'(0) : 65'(mq.size()));

         if (reset) begin
            m_pc = 32'h0;
            m_gen = 0;
            mq.delete();
            m_halted = 1'b0;
         end else begin
            if (pop) void'(mq.pop_front());
            if (ev && icache_req_ready) mq.push_back('{m_gen, cnt, m_pc});
            if (redirect_valid) begin
               m_pc = redirect_pc & 32'hFFFF_FFFC;
               m_gen++;
               m_halted = 1'b0;
            end else begin
               if (ev && icache_req_ready) m_pc = m_pc + 32'(4 * cnt);
               if (halt) m_halted = 1'b1;
            end
         end
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic rsp(input logic [31:0] base);
      icache_rsp_valid = 1'b1;
      for (int i = 0; i < PW; i++) icache_rsp_inst[i] = 32'hC0DE_0000 ^ (base + 32'(4 * i));
   endtask

   initial begin
      tick();
      cmp_on = 1'b1;
      #1;
      chk("reset_valid", 65'(icache_req_valid), 65'(0));
      chk("reset_outstanding", 65'(outstanding), 65'(0));
      chk("reset_push", 65'(|ib_push), 65'(0));

      // steady sequential fetch, responses one cycle after each request
      tick(); reset = 1'b0; icache_req_ready = 1'b1;
      #1; chk("seq_valid", 65'(icache_req_valid), 65'(1));
      chk("seq_addr0", 65'(icache_req_addr), 65'(32'h0));
      chk("seq_count0", 65'(icache_req_count), 65'(4));
      tick(); rsp(32'h0);
      #1; chk("seq_addr1", 65'(icache_req_addr), 65'(32'h10));
      chk("seq_lane0_pc", 65'(ib_push[0].pc), 65'(32'h0));
      chk("seq_lane3_pc", 65'(ib_push[3].pc), 65'(32'hC));
      chk("seq_lane3_inst", 65'(ib_push[3].inst), 65'(32'hC0DE_000C));
      tick(); rsp(32'h10);
      #1; chk("seq_addr2", 65'(icache_req_addr), 65'(32'h20));
      tick(); icache_req_ready = 1'b0; rsp(32'h20);
      #1; chk("seq_outstanding1", 65'(outstanding), 65'(1));
      tick(); icache_rsp_valid = 1'b0;
      #1; chk("seq_outstanding0", 65'(outstanding), 65'(0));

      // misaligned redirect target
      tick(); redirect_valid = 1'b1; redirect_pc = 32'h18; icache_req_ready = 1'b1;
      #1; chk("redir_gates_valid", 65'(icache_req_valid), 65'(0));
      tick(); redirect_valid = 1'b0;
      #1; chk("mis_addr", 65'(icache_req_addr), 65'(32'h18));
      chk("mis_count", 65'(icache_req_count), 65'(2));
      tick(); rsp(32'h18);
      #1; chk("mis_next_addr", 65'(icache_req_addr), 65'(32'h20));
      chk("mis_next_count", 65'(icache_req_count), 65'(4));
      chk("mis_lane1_pc", 65'(ib_push[1].pc), 65'(32'h1C));
      chk("mis_lane2_invalid", 65'(ib_push[2].valid), 65'(0));
      tick(); icache_req_ready = 1'b0; rsp(32'h20);

      // credit limit
      tick(); icache_rsp_valid = 1'b0; ib_available_slots = 6; icache_req_ready = 1'b1;
      #1; chk("credit_first", 65'(icache_req_valid), 65'(1));
      tick(); #1; chk("credit_blocked_a", 65'(icache_req_valid), 65'(0));
      tick(); #1; chk("credit_blocked_b", 65'(icache_req_valid), 65'(0));
      tick(); rsp(32'h30);
      #1; chk("credit_blocked_rsp", 65'(icache_req_valid), 65'(0));
      chk("credit_rsp_pc", 65'(ib_push[0].pc), 65'(32'h30));
      tick(); icache_rsp_valid = 1'b0; ib_available_slots = 2;
      #1; chk("credit_slots2", 65'(icache_req_valid), 65'(0));
      tick(); ib_available_slots = 3;
      #1; chk("credit_slots3", 65'(icache_req_valid), 65'(0));
      tick(); ib_available_slots = 6;
      #1; chk("credit_slots6", 65'(icache_req_valid), 65'(1));
      chk("credit_addr", 65'(icache_req_addr), 65'(32'h40));
      tick(); icache_req_ready = 1'b0; ib_available_slots = 16; rsp(32'h40);
      tick(); icache_rsp_valid = 1'b0;

      // redirect with two outstanding
      tick(); icache_req_ready = 1'b1;
      tick();
      tick(); redirect_valid = 1'b1; redirect_pc = 32'h100; rsp(32'h50);
      #1; chk("r2_outstanding2", 65'(outstanding), 65'(2));
      chk("r2_valid", 65'(icache_req_valid), 65'(0));
      chk("r2_drop_a", 65'(|ib_push), 65'(0));
      tick(); redirect_valid = 1'b0; rsp(32'h60);
      #1; chk("r2_outstanding1", 65'(outstanding), 65'(1));
      chk("r2_drop_b", 65'(|ib_push), 65'(0));
      chk("r2_new_valid", 65'(icache_req_valid), 65'(1));
      chk("r2_new_addr", 65'(icache_req_addr), 65'(32'h100));
      tick(); icache_req_ready = 1'b0; rsp(32'h100);
      #1; chk("r2_live_valid", 65'(ib_push[0].valid), 65'(1));
      chk("r2_live_pc", 65'(ib_push[0].pc), 65'(32'h100));
      tick(); icache_rsp_valid = 1'b0;
      #1; chk("r2_drained", 65'(outstanding), 65'(0));

      // halt with one outstanding
      tick(); icache_req_ready = 1'b1;
      tick(); halt = 1'b1; ib_available_slots = 4;
      #1; chk("halt_blocked", 65'(icache_req_valid), 65'(0));
      tick(); halt = 1'b0; ib_available_slots = 16; rsp(32'h110);
      #1; chk("halt_no_issue", 65'(icache_req_valid), 65'(0));
      chk("halt_rsp_pc", 65'(ib_push[3].pc), 65'(32'h11C));
      tick(); icache_rsp_valid = 1'b0;
      #1; chk("halt_sticky", 65'(icache_req_valid), 65'(0));
      tick(); redirect_valid = 1'b1; redirect_pc = 32'h40;
      tick(); redirect_valid = 1'b0;
      #1; chk("halt_resume_valid", 65'(icache_req_valid), 65'(1));
      chk("halt_resume_addr", 65'(icache_req_addr), 65'(32'h40));
      tick(); icache_req_ready = 1'b0; rsp(32'h40);
      tick(); icache_rsp_valid = 1'b0;

      // redirect, response and ready in the same cycle
      tick(); icache_req_ready = 1'b1;
      tick(); redirect_valid = 1'b1; redirect_pc = 32'h200; rsp(32'h50);
      #1; chk("coll_valid", 65'(icache_req_valid), 65'(0));
      chk("coll_drop", 65'(|ib_push), 65'(0));
      chk("coll_outstanding", 65'(outstanding), 65'(1));
      tick(); redirect_valid = 1'b0; icache_rsp_valid = 1'b0; icache_req_ready = 1'b0;
      #1; chk("coll_pc", 65'(icache_req_addr), 65'(32'h200));
      chk("coll_drained", 65'(outstanding), 65'(0));

      // PC wrap at the top of the address space
      tick(); redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF8; icache_req_ready = 1'b1;
      tick(); redirect_valid = 1'b0;
      #1; chk("wrap_addr", 65'(icache_req_addr), 65'(32'hFFFF_FFF8));
      chk("wrap_count", 65'(icache_req_count), 65'(2));
      tick(); icache_req_ready = 1'b0; rsp(32'hFFFF_FFF8);
      #1; chk("wrap_next_addr", 65'(icache_req_addr), 65'(32'h0));
      chk("wrap_lane1_pc", 65'(ib_push[1].pc), 65'(32'hFFFF_FFFC));
      chk("wrap_lane2_invalid", 65'(ib_push[2].valid), 65'(0));
      tick(); icache_rsp_valid = 1'b0; icache_req_ready = 1'b1;

      // reset mid-operation with a request in flight
      tick(); reset = 1'b1;
      #1; chk("midrst_valid", 65'(icache_req_valid), 65'(0));
      chk("midrst_outstanding", 65'(outstanding), 65'(0));
      tick(); reset = 1'b0; icache_req_ready = 1'b0;
      #1; chk("postrst_valid", 65'(icache_req_valid), 65'(1));
      chk("postrst_addr", 65'(icache_req_addr), 65'(32'h0));
      chk("postrst_outstanding", 65'(outstanding), 65'(0));
      tick();
      tick();

      cmp_on = 1'b0;
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
`default_nettype wire
